// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd F(4x4,3x3) datapath.
package winograd_pkg;

  localparam int unsigned TILE_IN  = 6;
  localparam int unsigned TILE_OUT = 4;
  localparam int unsigned ACC_W    = 40;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MAC, S_DONE} acc_state_t;

endpackage

// File: rtl/winograd_row_mac.sv
// One row of the Hadamard stage: acc_out[c] = acc_in[c] + U[c]*V[c], full-precision signed.
module winograd_row_mac
  import winograd_pkg::TILE_IN;
#(
  parameter int unsigned U_W   = 16,
  parameter int unsigned V_W   = 20,
  parameter int unsigned ACC_W = 40
) (
  input  logic signed [U_W-1:0]   u       [TILE_IN],
  input  logic signed [V_W-1:0]   v       [TILE_IN],
  input  logic signed [ACC_W-1:0] acc_in  [TILE_IN],
  output logic signed [ACC_W-1:0] acc_out [TILE_IN]
);

  localparam int unsigned P_W = U_W + V_W;

  logic signed [P_W-1:0] prod [TILE_IN];

  // Operands widened first so the product never truncates; the cast to ACC_W sign-extends.
  always_comb begin
    for (int c = 0; c < TILE_IN; c++) begin
      prod[c]    = P_W'(u[c]) * P_W'(v[c]);
      acc_out[c] = acc_in[c] + ACC_W'(prod[c]);
    end
  end

endmodule

// File: rtl/winograd_channel_accumulator.sv
// Row-serial accumulation of M = sum_c U_c .* V_c over a tile's input channels.
module winograd_channel_accumulator
  import winograd_pkg::TILE_IN, winograd_pkg::acc_state_t, winograd_pkg::S_IDLE,
         winograd_pkg::S_WAIT, winograd_pkg::S_MAC, winograd_pkg::S_DONE;
#(
  parameter int unsigned U_W      = 16,
  parameter int unsigned V_W      = 20,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned CH_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    ch_valid,
  output logic                    ch_ready,
  input  logic                    ch_last,
  input  logic signed [U_W-1:0]   U [TILE_IN][TILE_IN],
  input  logic signed [V_W-1:0]   V [TILE_IN][TILE_IN],
  output logic signed [ACC_W-1:0] M [TILE_IN][TILE_IN],
  output logic [CH_CNT_W-1:0]     ch_count,
  output logic                    done,
  output logic                    busy
);

  localparam logic [2:0] LAST_ROW = 3'(TILE_IN - 1);

  acc_state_t state_q, state_d;

  logic [2:0]             row_q;
  logic                   last_q;
  logic [CH_CNT_W-1:0]    ch_count_q;
  logic signed [U_W-1:0]   u_q   [TILE_IN][TILE_IN];
  logic signed [V_W-1:0]   v_q   [TILE_IN][TILE_IN];
  logic signed [ACC_W-1:0] acc_q [TILE_IN][TILE_IN];

  logic signed [U_W-1:0]   row_u   [TILE_IN];
  logic signed [V_W-1:0]   row_v   [TILE_IN];
  logic signed [ACC_W-1:0] row_acc [TILE_IN];
  logic signed [ACC_W-1:0] row_sum [TILE_IN];

  always_comb begin
    for (int c = 0; c < TILE_IN; c++) begin
      row_u[c]   = u_q[row_q][c];
      row_v[c]   = v_q[row_q][c];
      row_acc[c] = acc_q[row_q][c];
    end
  end

  winograd_row_mac #(
    .U_W   (U_W),
    .V_W   (V_W),
    .ACC_W (ACC_W)
  ) u_row_mac (
    .u       (row_u),
    .v       (row_v),
    .acc_in  (row_acc),
    .acc_out (row_sum)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start)    state_d = S_WAIT;
      S_WAIT: if (ch_valid) state_d = S_MAC;
      S_MAC:  if (row_q == LAST_ROW) state_d = last_q ? S_DONE : S_WAIT;
      S_DONE: if (!start)   state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      last_q     <= 1'b0;
      ch_count_q <= '0;
      for (int r = 0; r < TILE_IN; r++) begin
        for (int c = 0; c < TILE_IN; c++) begin
          u_q[r][c]   <= '0;
          v_q[r][c]   <= '0;
          acc_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      // Accumulators survive S_DONE and S_IDLE; only a new tile clears them.
      if (state_q == S_IDLE && start) begin
        ch_count_q <= '0;
        for (int r = 0; r < TILE_IN; r++) begin
          for (int c = 0; c < TILE_IN; c++) acc_q[r][c] <= '0;
        end
      end
      if (state_q == S_WAIT && ch_valid) begin
        u_q    <= U;
        v_q    <= V;
        last_q <= ch_last;
        row_q  <= '0;
      end
      if (state_q == S_MAC) begin
        for (int c = 0; c < TILE_IN; c++) acc_q[row_q][c] <= row_sum[c];
        if (row_q == LAST_ROW) ch_count_q <= ch_count_q + CH_CNT_W'(1);
        else                   row_q      <= row_q + 3'd1;
      end
    end
  end

  assign ch_ready = (state_q == S_WAIT);
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q == S_WAIT) || (state_q == S_MAC);
  assign ch_count = ch_count_q;
  assign M        = acc_q;

endmodule

// File: tb/tb_winograd_channel_accumulator.sv
// Scoreboard bench: stimulus pushes expected tiles, a monitor checks them when done rises.
module tb_winograd_channel_accumulator;

  localparam int U_W = 16, V_W = 20, ACC_W = 40, CH_CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n, start, ch_valid, ch_last, ch_ready, done, busy;
  logic signed [U_W-1:0]   u_in  [6][6];
  logic signed [V_W-1:0]   v_in  [6][6];
  logic signed [ACC_W-1:0] m_out [6][6];
  logic [CH_CNT_W-1:0]     ch_count;

  always #5 clk = ~clk;

  winograd_channel_accumulator #(
    .U_W(U_W), .V_W(V_W), .ACC_W(ACC_W), .CH_CNT_W(CH_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_last(ch_last), .U(u_in), .V(v_in), .M(m_out), .ch_count(ch_count), .done(done),
    .busy(busy)
  );

  typedef struct packed {
    logic [CH_CNT_W-1:0]   cnt;
    logic [36*ACC_W-1:0]   m;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     failures = 0;
  longint model [6][6];
  logic   done_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    logic signed [ACC_W-1:0] t;
    t = x[ACC_W-1:0];
    return longint'(t);
  endfunction

  // Monitor: on each rising done, compare M and ch_count against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
              logic signed [ACC_W-1:0] t;
              t = e.m[(i*6+j)*ACC_W +: ACC_W];
              chk($sformatf("M[%0d][%0d]", i, j), longint'(m_out[i][j]), longint'(t));
            end
          end
          chk("ch_count", longint'(ch_count), longint'(e.cnt));
        end
      end
      done_prev = done;
    end
  end

  task automatic scramble();
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        u_in[i][j] = U_W'($urandom);
        v_in[i][j] = V_W'($urandom);
      end
    end
  endtask

  // kind: 0 random, 1 U=2/V=-3, 2 U=i+j/V=ch+1, 3 extreme negatives
  task automatic set_chan(input int kind, input int ch);
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        case (kind)
          1: begin u_in[i][j] = 16'sd2;            v_in[i][j] = -20'sd3;          end
          2: begin u_in[i][j] = U_W'(i + j);       v_in[i][j] = V_W'(ch + 1);     end
          3: begin u_in[i][j] = -16'sd32768;       v_in[i][j] = -20'sd524288;     end
          default: begin u_in[i][j] = U_W'($urandom); v_in[i][j] = V_W'($urandom); end
        endcase
        model[i][j] += longint'(u_in[i][j]) * longint'(v_in[i][j]);
      end
    end
  endtask

  task automatic wait_ready(input int ch);
    int w = 0;
    while (!ch_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ch_ready_seen", longint'(ch_ready), 1);
    if (ch > 0) chk("no_early_done", longint'(done), 0);
  endtask

  task automatic run_tile(input int nch, input int kind, input int gap_max, output int lat);
    exp_t e;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) model[i][j] = 0;
    @(negedge clk);
    start = 1'b1;
    for (int ch = 0; ch < nch; ch++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      wait_ready(ch);
      set_chan(kind, ch);
      ch_last  = (ch == nch - 1);
      ch_valid = 1'b1;
      @(posedge clk);
      #1;
      ch_valid = 1'b0;
      ch_last  = 1'($urandom);
      scramble();
    end
    e.cnt = CH_CNT_W'(nch);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) e.m[(i*6+j)*ACC_W +: ACC_W] = model[i][j][ACC_W-1:0];
    sb_q.push_back(e);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_reached", longint'(done), 1);
  endtask

  task automatic end_tile();
    @(negedge clk);
    chk("done_held", longint'(done), 1);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("done_drop", longint'(done), 0);
    chk("busy_idle", longint'(busy), 0);
    chk("m00_retained", longint'(m_out[0][0]), wrap(model[0][0]));
    chk("m55_retained", longint'(m_out[5][5]), wrap(model[5][5]));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int nz;
    rst_n = 1'b0; start = 1'b0; ch_valid = 1'b0; ch_last = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    chk("rst_m23", longint'(m_out[2][3]), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ready", longint'(ch_ready), 0);
    chk("rst_count", longint'(ch_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single channel, then hold start high in S_DONE.
    run_tile(1, 1, 0, lat);
    chk("latency_1ch", lat, 7);
    repeat (3) begin
      @(negedge clk);
      chk("done_hold", longint'(done), 1);
      chk("m23_hold", longint'(m_out[2][3]), -6);
    end
    end_tile();

    // Re-raise start: accumulators clear, then idle in S_WAIT with ch_valid low.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_m23_clear", longint'(m_out[2][3]), 0);
    chk("restart_count", longint'(ch_count), 0);
    repeat (10) begin
      @(negedge clk);
      chk("wait_ready", longint'(ch_ready), 1);
      chk("wait_busy", longint'(busy), 1);
      chk("wait_done", longint'(done), 0);
      chk("wait_m44", longint'(m_out[4][4]), 0);
    end
    run_tile(3, 2, 2, lat);
    chk("m34_three_ch", longint'(m_out[3][4]), 6 * 7);
    end_tile();

    run_tile(16, 3, 0, lat);
    chk("m55_extreme", longint'(m_out[5][5]), longint'(1) << 38);
    end_tile();

    for (int t = 0; t < 6; t++) begin
      run_tile($urandom_range(1, 4), 0, 3, lat);
      end_tile();
    end

    // Reset in the middle of MAC row 3 abandons the tile.
    @(negedge clk);
    start = 1'b1;
    wait_ready(0);
    set_chan(0, 0);
    ch_last  = 1'b1;
    ch_valid = 1'b1;
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    nz = 0;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) if (m_out[i][j] != 0) nz++;
    chk("rst_mid_m_nonzero", nz, 0);
    chk("rst_mid_done", longint'(done), 0);
    chk("rst_mid_busy", longint'(busy), 0);
    chk("rst_mid_ready", longint'(ch_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_count", longint'(ch_count), 0);

    run_tile(2, 0, 1, lat);
    end_tile();

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
